// File: rtl/menu_ctl_pkg.sv
// rtl/menu_ctl_pkg.sv - shared FSM encoding and default timing constants for menu_ctl
package menu_ctl_pkg;

  typedef enum logic [1:0] {
    MENU  = 2'd0,
    START = 2'd1,
    GAME  = 2'd2,
    OVER  = 2'd3
  } state_t;

  // 10 ms of stable input at a 65 MHz pixel clock
  localparam int DEBOUNCE_CYCLES_DEFAULT = 650000;
  localparam int OVER_FRAMES_DEFAULT     = 120;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser, debounce counter and one-cycle press pulse
import menu_ctl_pkg::*;

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic pclk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      // any glitch back to the accepted level restarts the stability window
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/menu_ctl.sv
// rtl/menu_ctl.sv - button conditioning, frame tick and menu/game FSM driving the renderer's
// player selection; selection changes land on frame boundaries only.
import menu_ctl_pkg::*;

module menu_ctl #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int OVER_FRAMES     = OVER_FRAMES_DEFAULT
) (
  input  logic pclk,
  input  logic rst_n,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_enter,
  input  logic vsync_in,
  input  logic game_over,
  output logic player_count,
  output logic menu_active,
  output logic game_start
);

  localparam int FW = (OVER_FRAMES > 1) ? $clog2(OVER_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(OVER_FRAMES - 1);

  logic          up_press;
  logic          down_press;
  logic          enter_press;
  logic          vsync_q;
  logic          vsync_prev;
  logic          tick;
  logic          pending_sel;
  logic [FW-1:0] frame_cnt;
  state_t        state;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .pclk  (pclk),
    .rst_n (rst_n),
    .btn   (btn_up),
    .press (up_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .pclk  (pclk),
    .rst_n (rst_n),
    .btn   (btn_down),
    .press (down_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .pclk  (pclk),
    .rst_n (rst_n),
    .btn   (btn_enter),
    .press (enter_press)
  );

  assign tick = vsync_q & ~vsync_prev;

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state        <= MENU;
      pending_sel  <= 1'b0;
      player_count <= 1'b0;
      menu_active  <= 1'b1;
      game_start   <= 1'b0;
      frame_cnt    <= '0;
      vsync_q      <= 1'b0;
      vsync_prev   <= 1'b0;
    end else begin
      vsync_q    <= vsync_in;
      vsync_prev <= vsync_q;
      game_start <= 1'b0;
      case (state)
        MENU: begin
          if (enter_press) begin
            // publish the final choice together with the start pulse
            state        <= START;
            game_start   <= 1'b1;
            menu_active  <= 1'b0;
            player_count <= pending_sel;
          end else begin
            if (up_press && !down_press) begin
              pending_sel <= 1'b0;
            end else if (down_press && !up_press) begin
              pending_sel <= 1'b1;
            end
            if (tick) begin
              player_count <= pending_sel;
            end
          end
        end
        START: begin
          state <= GAME;
        end
        GAME: begin
          if (game_over) begin
            state     <= OVER;
            frame_cnt <= '0;
          end
        end
        OVER: begin
          if (tick) begin
            if (frame_cnt == FRAME_LAST) begin
              state       <= MENU;
              menu_active <= 1'b1;
              frame_cnt   <= '0;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        default: state <= MENU;
      endcase
    end
  end

endmodule

// File: tb/tb_menu_ctl.sv
// tb/tb_menu_ctl.sv - directed self-checking bench for menu_ctl (DEBOUNCE_CYCLES=4, OVER_FRAMES=2)
import menu_ctl_pkg::*;

module tb_menu_ctl;

  logic pclk = 1'b0;
  logic rst_n;
  logic btn_up;
  logic btn_down;
  logic btn_enter;
  logic vsync_in;
  logic game_over;
  logic player_count;
  logic menu_active;
  logic game_start;

  int n_checks = 0;
  int n_errors = 0;

  menu_ctl #(.DEBOUNCE_CYCLES(4), .OVER_FRAMES(2)) dut (
    .pclk         (pclk),
    .rst_n        (rst_n),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_enter    (btn_enter),
    .vsync_in     (vsync_in),
    .game_over    (game_over),
    .player_count (player_count),
    .menu_active  (menu_active),
    .game_start   (game_start)
  );

  always #5 pclk = ~pclk;

  // 40-cycle frame: rising edge every 40 clocks, high for 4
  initial begin
    vsync_in = 1'b0;
    forever begin
      repeat (36) @(posedge pclk);
      #1 vsync_in = 1'b1;
      repeat (4) @(posedge pclk);
      #1 vsync_in = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge pclk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_vsync_rise(input string tag);
    logic prev;
    logic found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      prev = vsync_in;
      cyc();
      if (vsync_in && !prev) found = 1'b1;
    end
    check(tag, found, 1'b1);
  endtask

  int up_cnt, up_idx, down_cnt, enter_cnt, gs_cnt;
  logic saw_both;

  initial begin
    rst_n = 1'b0; btn_up = 1'b0; btn_down = 1'b1; btn_enter = 1'b0; game_over = 1'b0;

    // reset with down held
    repeat (3) cyc();
    check("rst_player_count", player_count, 1'b0);
    check("rst_menu_active", menu_active, 1'b1);
    check("rst_game_start", game_start, 1'b0);
    check("rst_state", dut.state, MENU);
    rst_n = 1'b1;
    repeat (6) cyc();
    check("down_press_early", dut.down_press, 1'b0);
    cyc();
    check("down_press_at_7", dut.down_press, 1'b1);
    cyc();
    check("down_press_width", dut.down_press, 1'b0);
    check("pending_after_down", dut.pending_sel, 1'b1);
    check("pc_before_frame", player_count, 1'b0);
    wait_vsync_rise("vsync_timeout_1");
    check("pc_at_vsync_rise", player_count, 1'b0);
    cyc();
    check("pc_tick_cycle", player_count, 1'b0);
    cyc();
    check("pc_after_tick", player_count, 1'b1);

    // bounce on up
    up_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      btn_up = ~btn_up;
      repeat (2) begin cyc(); if (dut.up_press) up_cnt++; end
    end
    check("bounce_no_press", up_cnt, 0);
    btn_up = 1'b1;
    up_cnt = 0; up_idx = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      if (dut.up_press) begin up_cnt++; up_idx = i; end
    end
    check("bounce_one_press", up_cnt, 1);
    check("bounce_latency", up_idx, 7);
    check("bounce_pending", dut.pending_sel, 1'b0);

    // simultaneous up and down
    btn_up = 1'b0; btn_down = 1'b0;
    repeat (10) cyc();
    wait_vsync_rise("vsync_timeout_2");
    repeat (3) cyc();
    check("simul_pc_pre", player_count, 1'b0);
    btn_up = 1'b1; btn_down = 1'b1;
    saw_both = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (dut.up_press && dut.down_press) saw_both = 1'b1;
    end
    check("simul_both_pulsed", saw_both, 1'b1);
    repeat (120) cyc();
    check("simul_pending", dut.pending_sel, 1'b0);
    check("simul_pc", player_count, 1'b0);

    // select two players, then start mid-frame
    btn_up = 1'b0; btn_down = 1'b0;
    repeat (10) cyc();
    wait_vsync_rise("vsync_timeout_3");
    btn_down = 1'b1;
    repeat (7) cyc();
    check("start_down_press", dut.down_press, 1'b1);
    btn_enter = 1'b1;
    repeat (7) cyc();
    check("start_enter_press", dut.enter_press, 1'b1);
    check("start_pending", dut.pending_sel, 1'b1);
    check("start_pc_pre", player_count, 1'b0);
    check("start_gs_pre", game_start, 1'b0);
    cyc();
    check("start_gs", game_start, 1'b1);
    check("start_pc", player_count, 1'b1);
    check("start_menu_active", menu_active, 1'b0);
    check("start_state", dut.state, START);
    cyc();
    check("start_gs_width", game_start, 1'b0);
    check("game_state", dut.state, GAME);

    // presses ignored in GAME
    btn_enter = 1'b0;
    repeat (10) cyc();
    btn_enter = 1'b1; btn_up = 1'b1;
    gs_cnt = 0;
    for (int i = 0; i < 14; i++) begin cyc(); if (game_start) gs_cnt++; end
    check("game_no_start", gs_cnt, 0);
    check("game_state_hold", dut.state, GAME);
    check("game_pending_hold", dut.pending_sel, 1'b1);

    // game over hold for two frames
    wait_vsync_rise("vsync_timeout_4");
    repeat (5) cyc();
    game_over = 1'b1;
    cyc();
    game_over = 1'b0;
    check("over_state", dut.state, OVER);
    wait_vsync_rise("vsync_timeout_5");
    cyc();
    cyc();
    check("over_frame_cnt", dut.frame_cnt, 1);
    check("over_state_hold", dut.state, OVER);
    wait_vsync_rise("vsync_timeout_6");
    check("over_ma_pre", menu_active, 1'b0);
    cyc();
    check("over_ma_tick", menu_active, 1'b0);
    cyc();
    check("over_ma_back", menu_active, 1'b1);
    check("over_to_menu", dut.state, MENU);
    check("over_gs", game_start, 1'b0);

    // enter/up held across the return to MENU give no new press
    gs_cnt = 0;
    for (int i = 0; i < 12; i++) begin cyc(); if (game_start) gs_cnt++; end
    check("held_no_start", gs_cnt, 0);
    check("held_state", dut.state, MENU);
    check("held_pending", dut.pending_sel, 1'b1);

    // reset during OVER with a debounce counter at 3
    btn_enter = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    repeat (10) cyc();
    btn_enter = 1'b1;
    repeat (8) cyc();
    check("rst2_start", game_start, 1'b1);
    cyc();
    btn_enter = 1'b0;
    game_over = 1'b1;
    cyc();
    game_over = 1'b0;
    check("rst2_over", dut.state, OVER);
    btn_down = 1'b1;
    repeat (5) cyc();
    check("rst2_cnt3", dut.u_down.cnt, 3);
    rst_n = 1'b0;
    cyc();
    check("rst2_state", dut.state, MENU);
    check("rst2_ma", menu_active, 1'b1);
    check("rst2_pc", player_count, 1'b0);
    check("rst2_pending", dut.pending_sel, 1'b0);
    check("rst2_cnt0", dut.u_down.cnt, 0);
    check("rst2_frame0", dut.frame_cnt, 0);
    rst_n = 1'b1; btn_down = 1'b0;
    down_cnt = 0; up_cnt = 0; enter_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (dut.down_press) down_cnt++;
      if (dut.up_press) up_cnt++;
      if (dut.enter_press) enter_cnt++;
    end
    check("rst2_no_down", down_cnt, 0);
    check("rst2_no_up", up_cnt, 0);
    check("rst2_no_enter", enter_cnt, 0);
    check("rst2_pending_end", dut.pending_sel, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
